// File: rtl/fp16_pkg.sv
// Shared definitions for the sequential FP16 multiplier: field widths, bias,
// saturation value, FSM encoding and operand-unpack helpers.
package fp16_pkg;

    localparam int unsigned FP16_EXP_W      = 5;
    localparam int unsigned FP16_MANT_W     = 10;
    localparam int unsigned FP16_SIG_W      = FP16_MANT_W + 1;
    localparam int unsigned FP16_PROD_W     = 2 * FP16_SIG_W;
    localparam int unsigned FP16_POS_W      = $clog2(FP16_PROD_W);
    localparam int unsigned FP16_BIAS       = 15;
    localparam logic [14:0] FP16_MAX_FINITE = 15'h7BFF;

    typedef enum logic [2:0] {
        StIdle,
        StUnpack,
        StMul,
        StNorm,
        StDenorm,
        StRound,
        StOut
    } state_e;

    // Significand with hidden bit; denormals get a hidden 0.
    function automatic logic [FP16_SIG_W-1:0] fp16_sig(input logic [15:0] x);
        return {(x[14:10] != '0), x[9:0]};
    endfunction

    // Effective exponent; denormals behave as exponent 1, zero stays 0.
    function automatic logic [FP16_EXP_W-1:0] fp16_exp(input logic [15:0] x);
        logic [FP16_EXP_W-1:0] e;
        e = x[14:10];
        if (x[14:10] == '0) begin
            e = (x[9:0] != '0) ? 5'd1 : 5'd0;
        end
        return e;
    endfunction

    function automatic logic fp16_is_zero(input logic [15:0] x);
        return (x[14:0] == '0);
    endfunction

endpackage

// File: rtl/fp16_lzd.sv
// Leading-one detector over the 22-bit raw product.
module fp16_lzd
    import fp16_pkg::*;
(
    input  logic [FP16_PROD_W-1:0] vec_i,
    output logic [FP16_POS_W-1:0]  pos_o,
    output logic                   valid_o
);

    // Ascending scan: the highest set bit is the last one written.
    always_comb begin
        pos_o   = '0;
        valid_o = 1'b0;
        for (int i = 0; i < int'(FP16_PROD_W); i++) begin
            if (vec_i[i]) begin
                pos_o   = FP16_POS_W'(i);
                valid_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fp16_mul.sv
// Sequential FP16 multiplier: unpack, 11-cycle shift-add, normalise,
// denormalise, round, pack with saturation (no Inf/NaN handling).
// Optional macro FP16_MUL_RNE_EN selects round-to-nearest-even; otherwise
// rounding is round-half-up and no sticky state is built.
module fp16_mul
    import fp16_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] data_a,
    input  logic [15:0] data_b,
    input  logic        input_valid,
    output logic [15:0] data_p,
    output logic        output_update,
    output logic        idle
);

    localparam logic signed [7:0] ExpBias = 8'(FP16_BIAS);
    localparam logic [3:0]        MulIter = 4'(FP16_SIG_W);

    state_e state_q, state_d;

    logic [15:0]            opa_q, opa_d, opb_q, opb_d;
    logic                   sign_q, sign_d;
    logic signed [7:0]      exp_q, exp_d;
    logic [FP16_PROD_W-1:0] mcand_q, mcand_d, prod_q, prod_d;
    logic [FP16_SIG_W-1:0]  mplier_q, mplier_d, mant_q, mant_d;
    logic [3:0]             cnt_q, cnt_d;
    logic                   guard_q, guard_d;
    logic                   zero_q, zero_d;
    logic [15:0]            data_p_q, data_p_d;
    logic                   upd_q, upd_d;
    logic                   idle_q, idle_d;
`ifdef FP16_MUL_RNE_EN
    logic                   sticky_q, sticky_d;
    logic [9:0]             norm_low;
    logic                   den_lost;
`endif

    logic [FP16_POS_W-1:0]  lead_pos;
    logic                   lead_valid;
    logic [11:0]            norm_top;
    logic signed [7:0]      exp_a_s, exp_b_s, lead_s;
    logic [7:0]             den_sh;
    logic [11:0]            den_top;
    logic                   round_inc;
    logic [11:0]            rnd_sum;

    fp16_lzd u_lzd (
        .vec_i   (prod_q),
        .pos_o   (lead_pos),
        .valid_o (lead_valid)
    );

    assign exp_a_s = {3'b000, fp16_exp(opa_q)};
    assign exp_b_s = {3'b000, fp16_exp(opb_q)};
    assign lead_s  = {3'b000, lead_pos};

    // Align the leading one to bit 21: [21:11] mantissa, [10] guard.
`ifdef FP16_MUL_RNE_EN
    assign {norm_top, norm_low} = prod_q << (5'(FP16_PROD_W - 1) - lead_pos);
`else
    assign norm_top = 12'((prod_q << (5'(FP16_PROD_W - 1) - lead_pos)) >> 10);
`endif

    // Right shift of {mant, guard}; the new guard is the last bit shifted out.
    assign den_sh  = 8'sd1 - exp_q;
    assign den_top = {mant_q, guard_q} >> den_sh;
`ifdef FP16_MUL_RNE_EN
    assign den_lost  = |({mant_q, guard_q} & ((12'd1 << den_sh) - 12'd1));
    assign round_inc = guard_q & (sticky_q | mant_q[0]);
`else
    assign round_inc = guard_q;
`endif
    assign rnd_sum = {1'b0, mant_q} + {11'b0, round_inc};

    // Next-state and datapath updates; every register holds unless its state acts.
    always_comb begin
        state_d  = state_q;
        opa_d    = opa_q;
        opb_d    = opb_q;
        sign_d   = sign_q;
        exp_d    = exp_q;
        mcand_d  = mcand_q;
        prod_d   = prod_q;
        mplier_d = mplier_q;
        mant_d   = mant_q;
        cnt_d    = cnt_q;
        guard_d  = guard_q;
        zero_d   = zero_q;
        data_p_d = data_p_q;
        upd_d    = 1'b0;
        idle_d   = idle_q;
`ifdef FP16_MUL_RNE_EN
        sticky_d = sticky_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (input_valid) begin
                    opa_d   = data_a;
                    opb_d   = data_b;
                    idle_d  = 1'b0;
                    state_d = StUnpack;
                end else begin
                    idle_d  = 1'b1;
                end
            end
            StUnpack: begin
                sign_d   = opa_q[15] ^ opb_q[15];
                exp_d    = exp_a_s + exp_b_s - ExpBias;
                zero_d   = fp16_is_zero(opa_q) | fp16_is_zero(opb_q);
                mcand_d  = {{FP16_SIG_W{1'b0}}, fp16_sig(opa_q)};
                mplier_d = fp16_sig(opb_q);
                prod_d   = '0;
                mant_d   = '0;
                guard_d  = 1'b0;
`ifdef FP16_MUL_RNE_EN
                sticky_d = 1'b0;
`endif
                if (zero_d) begin
                    state_d = StOut;
                end else begin
                    cnt_d   = MulIter;
                    state_d = StMul;
                end
            end
            StMul: begin
                if (mplier_q[0]) begin
                    prod_d = prod_q + mcand_q;
                end
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = StNorm;
                end
            end
            StNorm: begin
                if (lead_valid) begin
                    mant_d  = norm_top[11:1];
                    guard_d = norm_top[0];
                    exp_d   = exp_q + lead_s - 8'sd20;
`ifdef FP16_MUL_RNE_EN
                    sticky_d = |norm_low;
`endif
                end else begin
                    mant_d  = '0;
                    guard_d = 1'b0;
                end
                state_d = StDenorm;
            end
            StDenorm: begin
                if (exp_q < 8'sd1) begin
                    exp_d = 8'sd0;
                    if (den_sh > 8'd12) begin
                        mant_d  = '0;
                        guard_d = 1'b0;
`ifdef FP16_MUL_RNE_EN
                        sticky_d = sticky_q | guard_q | (|mant_q);
`endif
                    end else begin
                        mant_d  = den_top[11:1];
                        guard_d = den_top[0];
`ifdef FP16_MUL_RNE_EN
                        sticky_d = sticky_q | den_lost;
`endif
                    end
                end
                state_d = StRound;
            end
            StRound: begin
                if (rnd_sum[11]) begin
                    mant_d = rnd_sum[11:1];
                    exp_d  = exp_q + 8'sd1;
                end else begin
                    mant_d = rnd_sum[10:0];
                    // A denormal that rounds up into bit 10 becomes the smallest normal.
                    if (exp_q == 8'sd0 && rnd_sum[10]) begin
                        exp_d = 8'sd1;
                    end
                end
                state_d = StOut;
            end
            StOut: begin
                if (exp_q > 8'sd30) begin
                    data_p_d = {sign_q, FP16_MAX_FINITE};
                end else if (zero_q || mant_q == '0) begin
                    data_p_d = 16'h0000;
                end else begin
                    data_p_d = {sign_q, exp_q[4:0], mant_q[9:0]};
                end
                upd_d   = 1'b1;
                idle_d  = 1'b1;
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
                idle_d  = 1'b1;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            opa_q    <= '0;
            opb_q    <= '0;
            sign_q   <= 1'b0;
            exp_q    <= '0;
            mcand_q  <= '0;
            prod_q   <= '0;
            mplier_q <= '0;
            mant_q   <= '0;
            cnt_q    <= '0;
            guard_q  <= 1'b0;
            zero_q   <= 1'b0;
            data_p_q <= '0;
            upd_q    <= 1'b0;
            idle_q   <= 1'b1;
`ifdef FP16_MUL_RNE_EN
            sticky_q <= 1'b0;
`endif
        end else begin
            opa_q    <= opa_d;
            opb_q    <= opb_d;
            sign_q   <= sign_d;
            exp_q    <= exp_d;
            mcand_q  <= mcand_d;
            prod_q   <= prod_d;
            mplier_q <= mplier_d;
            mant_q   <= mant_d;
            cnt_q    <= cnt_d;
            guard_q  <= guard_d;
            zero_q   <= zero_d;
            data_p_q <= data_p_d;
            upd_q    <= upd_d;
            idle_q   <= idle_d;
`ifdef FP16_MUL_RNE_EN
            sticky_q <= sticky_d;
`endif
        end
    end

    assign data_p        = data_p_q;
    assign output_update = upd_q;
    assign idle          = idle_q;

endmodule

// File: tb/tb_fp16_mul.sv
// Self-checking bench for fp16_mul: vector table through a scoreboard,
// plus busy-input and mid-operation reset sequences.
module tb_fp16_mul;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] data_a = '0;
    logic [15:0] data_b = '0;
    logic        input_valid = 1'b0;
    logic [15:0] data_p;
    logic        output_update;
    logic        idle;

    int cyc = 0;
    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] p;
        int          lat;
    } vec_t;

    typedef struct {
        logic [15:0] p;
        int          lat;
        int          k;
    } exp_t;

    localparam int NumVec = 15;
    vec_t vecs[NumVec];
    exp_t sb[$];
    exp_t got;

    fp16_mul dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .data_a        (data_a),
        .data_b        (data_b),
        .input_valid   (input_valid),
        .data_p        (data_p),
        .output_update (output_update),
        .idle          (idle)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Scoreboard consumer: every update pulse must match the oldest expectation.
    always @(negedge clk) begin
        if (rst_n && output_update) begin
            if (sb.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_update: got pulse with data_p %h, required no pulse",
                         data_p);
            end else begin
                got = sb.pop_front();
                check("data_p", data_p, got.p);
                check("latency", cyc - got.k, got.lat);
                check("idle_at_out", idle, 1);
            end
        end
    end

    // Called at a negedge; returns just after the accepting edge.
    task automatic start_op(input logic [15:0] a, input logic [15:0] b,
                            input logic [15:0] p, input int lat);
        int t;
        t = 0;
        while (!idle && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!idle) check("idle_wait", idle, 1);
        data_a      = a;
        data_b      = b;
        input_valid = 1'b1;
        @(posedge clk);
        #1;
        sb.push_back('{p: p, lat: lat, k: cyc});
        input_valid = 1'b0;
        check("idle_busy", idle, 0);
    endtask

    task automatic wait_done();
        int t;
        t = 0;
        while (sb.size() != 0 && t < 40) begin
            @(negedge clk);
            t++;
        end
        if (sb.size() != 0) begin
            n_vec++;
            n_err++;
            $display("FAIL timeout: got no update within 40 cycles, required %0d pending results",
                     sb.size());
            sb.delete();
        end
    endtask

    initial begin
        vecs[0]  = '{a: 16'h3C00, b: 16'h4000, p: 16'h4000, lat: 16};
        vecs[1]  = '{a: 16'h7BFF, b: 16'h4000, p: 16'h7BFF, lat: 16};
        vecs[2]  = '{a: 16'hFBFF, b: 16'h4000, p: 16'hFBFF, lat: 16};
        vecs[3]  = '{a: 16'h0000, b: 16'h4500, p: 16'h0000, lat: 2};
        vecs[4]  = '{a: 16'h8000, b: 16'h3C00, p: 16'h0000, lat: 2};
        vecs[5]  = '{a: 16'h0001, b: 16'h3C00, p: 16'h0001, lat: 16};
        vecs[6]  = '{a: 16'h0400, b: 16'h3800, p: 16'h0200, lat: 16};
        vecs[7]  = '{a: 16'h0001, b: 16'h0001, p: 16'h0000, lat: 16};
`ifdef FP16_MUL_RNE_EN
        vecs[8]  = '{a: 16'h3C03, b: 16'h3E00, p: 16'h3E04, lat: 16};
`else
        vecs[8]  = '{a: 16'h3C03, b: 16'h3E00, p: 16'h3E05, lat: 16};
`endif
        vecs[9]  = '{a: 16'h3C01, b: 16'h3E00, p: 16'h3E02, lat: 16};
        vecs[10] = '{a: 16'hC000, b: 16'h4200, p: 16'hC600, lat: 16};
        vecs[11] = '{a: 16'h4400, b: 16'h4400, p: 16'h4C00, lat: 16};
        vecs[12] = '{a: 16'h3C00, b: 16'h8000, p: 16'h0000, lat: 2};
        vecs[13] = '{a: 16'h03FF, b: 16'h3C01, p: 16'h0400, lat: 16};
        vecs[14] = '{a: 16'h3DA8, b: 16'h3DA8, p: 16'h4000, lat: 16};

        repeat (3) @(negedge clk);
        check("rst_data_p", data_p, 0);
        check("rst_update", output_update, 0);
        check("rst_idle", idle, 1);

        // First vector is driven in the same step as reset release.
        rst_n = 1'b1;
        for (int i = 0; i < NumVec; i++) begin
            start_op(vecs[i].a, vecs[i].b, vecs[i].p, vecs[i].lat);
            wait_done();
        end

        // input_valid while busy must be ignored.
        start_op(16'h3C00, 16'h4000, 16'h4000, 16);
        repeat (4) @(negedge clk);
        data_a      = 16'h7BFF;
        data_b      = 16'h7BFF;
        input_valid = 1'b1;
        check("busy_idle", idle, 0);
        check("data_p_held", data_p, vecs[NumVec-1].p);
        @(negedge clk);
        input_valid = 1'b0;
        wait_done();

        // Asynchronous reset mid-multiply abandons the operation.
        start_op(16'h3C03, 16'h3E00, 16'h3E04, 16);
        repeat (5) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_data_p", data_p, 0);
        check("midrst_update", output_update, 0);
        check("midrst_idle", idle, 1);
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (25) @(negedge clk);
        check("postrst_data_p", data_p, 0);
        check("postrst_idle", idle, 1);
        start_op(16'h3C01, 16'h3E00, 16'h3E02, 16);
        wait_done();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/fp16_mul.md
FP16_MUL -- requirements
Module: fp16_mul

Interface
REQ-001 SHALL: clk  input  1  single clock; all state changes on the rising edge.
REQ-002 SHALL: rst_n  input  1  reset, asynchronous and active-low.
REQ-003 SHALL: data_a  input  16  multiplicand, FP16 (sign[15], exp[14:10], mant[9:0]).
REQ-004 SHALL: data_b  input  16  multiplier, FP16.
REQ-005 SHALL: input_valid  input  1  operands present; sampled only in IDLE.
REQ-006 SHALL: data_p  output  16  registered product; held until the next OUT.
REQ-007 SHALL: output_update  output  1  one-cycle pulse when data_p is updated.
REQ-008 SHALL: idle  output  1  high when the next input_valid will be accepted.

Function
REQ-009 SHALL: FSM states IDLE, UNPACK, MUL, NORM, DENORM, ROUND, OUT; after OUT the FSM returns to IDLE.
REQ-010 SHALL: IDLE with input_valid=1 -> capture both operands, idle<=0, go to UNPACK; input_valid=0 -> idle<=1, stay.
REQ-011 SHALL: input_valid outside IDLE is ignored.
REQ-012 SHALL: operand unpack -- exp==0 and mant!=0 is denormal (exp=1, hidden bit 0); exp!=0 gives hidden bit 1. Inf/NaN encodings are treated as normals; no special handling.
REQ-013 SHALL: UNPACK -- sign_p = sign_a ^ sign_b; exp_p = exp_a + exp_b - 15 (signed, 8 bits). If either operand is zero, go directly to OUT; otherwise load the iteration counter with 11 and go to MUL.
REQ-014 SHALL: MUL is sequential shift-add, one multiplier bit per cycle, 11 cycles, giving a 22-bit product.
REQ-015 SHALL: NORM -- leading one of the product at bit p -> mant = 11 bits from p downward, guard = next bit, sticky = OR of remaining bits, exp_p += p - 20. A zero product yields mant = 0.
REQ-016 SHALL: DENORM -- if exp_p < 1, shift mant right by 1 - exp_p, with guard = last bit shifted out and sticky accumulating all shifted-out bits, then set exp_p = 0. A shift greater than 11 gives mant = 0.
REQ-017 SHALL: ROUND -- mant += round increment (see Configuration). A carry out of bit 10 -> shift mant right 1 and increment exp_p. When exp_p == 0, a result with bit 10 set -> exp_p = 1.
REQ-018 SHALL: OUT -- if exp_p > 30, data_p = {sign_p, 15'h7BFF} (saturate, no Inf). Otherwise, if the zero path was taken or mant == 0, data_p = 16'h0000. Otherwise data_p = {sign_p, exp_p[4:0], mant[9:0]}. In all cases output_update <= 1 and idle <= 1.
REQ-019 SHALL: latency -- input sampled at edge k gives the output_update pulse after edge k+16 on the normal path and after edge k+2 on the zero path.
REQ-020 SHALL: a new operand pair can be accepted no earlier than the edge after OUT.

Reset
REQ-021 SHALL: rst_n low, at any time including mid-operation, immediately forces state IDLE, data_p = 16'h0000, output_update = 0, idle = 1, counter = 0, and clears internal registers.
REQ-022 SHALL: after rst_n deasserts, the block accepts input_valid on the first rising edge.

Configuration
REQ-023 SHALL: the feature macro is FP16_MUL_RNE_EN.
REQ-024 SHALL: with FP16_MUL_RNE_EN defined, the round increment = guard & (sticky | mant[0]), i.e. round-to-nearest-even.
REQ-025 SHALL: without FP16_MUL_RNE_EN, the round increment = guard (round-half-up), and sticky logic is not synthesized.

Structure
REQ-026 SHALL: shared package fp16_pkg holds FP16_BIAS = 15, FP16_MAX_FINITE = 15'h7BFF, field widths, and the FSM state encoding.
REQ-027 SHALL: one sub-module, fp16_lzd, is a 22-bit leading-one detector used by NORM.
REQ-028 SHALL: the RTL is 120-400 lines in total.

Verification
REQ-029 SHALL: 0x3C00 x 0x4000 -> data_p = 0x4000, output_update one cycle, 16 edges after acceptance.
REQ-030 SHALL: 0x7BFF x 0x4000 -> 0x7BFF; 0xFBFF x 0x4000 -> 0xFBFF (saturation).
REQ-031 SHALL: 0x0000 x 0x4500 -> 0x0000; 0x8000 x 0x3C00 -> 0x0000; both via the 2-edge zero path.
REQ-032 SHALL: denormals -- 0x0001 x 0x3C00 -> 0x0001; 0x0400 x 0x3800 -> 0x0200; 0x0001 x 0x0001 -> 0x0000.
REQ-033 SHALL: rounding -- 0x3C03 x 0x3E00 -> 0x3E04 with FP16_MUL_RNE_EN, 0x3E05 without; 0x3C01 x 0x3E00 -> 0x3E02 in both builds.
REQ-034 SHALL: control -- input_valid pulsed during MUL is ignored and the result is unchanged. rst_n pulsed low mid-MUL -> idle = 1, output_update = 0, data_p = 0 with no pulse afterwards, and the next operation works.
